// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared defaults for the register file with scoreboard
package reg_file_sb_pkg;
    localparam int PC_IDX       = 15;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 4;
    localparam int NUM_REGS_DEF = PC_IDX;
    localparam int NUM_RD_DEF   = 3;
    localparam int CNT_W_DEF    = 2;
endpackage

// File: rtl/reg_pending_cnt.sv
// reg_pending_cnt: saturating/flooring up-down pending-write counter
module reg_pending_cnt
    import reg_file_sb_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr ? '0 :
                (inc && !dec && cnt_q != '1) ? cnt_q + 1'b1 :
                (dec && !inc && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with write-back bypass and
// per-register pending-write scoreboard
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] src,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     write_back_en,
    input  logic [ADDR_W-1:0]        WB_dest,
    input  logic [DATA_W-1:0]        WB_result,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_dest,
    input  logic                     flush,
    output logic                     issue_stall
);
    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [CNT_W-1:0]  cnt    [NUM_REGS];
    logic              wb_valid, issue_valid;
    assign wb_valid    = write_back_en && ({1'b0, WB_dest} < NREGS);
    assign issue_valid = issue_en && ({1'b0, issue_dest} < NREGS);
    // A same-cycle write-back frees a slot, so a full counter does not stall then
    assign issue_stall = issue_valid && cnt[issue_dest] == '1 &&
                         !(wb_valid && WB_dest == issue_dest);
    always_comb begin
        regs_d = regs_q;
        if (wb_valid) regs_d[WB_dest] = WB_result;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_W'(i);
        end else begin
            regs_q <= regs_d;
        end
    end
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        reg_pending_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (flush),
            .inc (issue_en && !issue_stall && issue_dest == ADDR_W'(r)),
            .dec (write_back_en && WB_dest == ADDR_W'(r)),
            .cnt (cnt[r])
        );
    end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] s;
        logic              v, byp;
        assign s   = src[k*ADDR_W +: ADDR_W];
        assign v   = {1'b0, s} < NREGS;
        assign byp = wb_valid && WB_dest == s;
        assign rdata[k*DATA_W +: DATA_W] = !v ? '0 : byp ? WB_result : regs_q[s];
        // Last outstanding write landing this cycle is covered by the bypass
        assign rd_busy[k] = v && cnt[s] != '0 && !(byp && cnt[s] == CNT_W'(1));
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and random checks of reg_file_sb against a
// behavioural array model
module tb_reg_file_sb;
    localparam int DW = 32, AW = 4, NR = 15, RD = 3, CMAX = 3;
    logic clk = 1'b0;
    logic rst, wbe, ie, flush, stall;
    logic [RD*AW-1:0] src;
    logic [RD*DW-1:0] rdata;
    logic [RD-1:0] rd_busy;
    logic [AW-1:0] wbd, idst;
    logic [DW-1:0] wbr;
    int checks = 0, failures = 0;
    int unsigned m_reg [NR];
    int m_cnt [NR];

    reg_file_sb dut (
        .clk(clk), .rst(rst), .src(src), .rdata(rdata), .rd_busy(rd_busy),
        .write_back_en(wbe), .WB_dest(wbd), .WB_result(wbr),
        .issue_en(ie), .issue_dest(idst), .flush(flush), .issue_stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_stall();
        return ie && idst < NR && m_cnt[idst] == CMAX && !(wbe && wbd == idst);
    endfunction

    task automatic check_outputs(string tag);
        for (int k = 0; k < RD; k++) begin
            int s;
            logic [DW-1:0] e;
            logic b;
            s = int'(src[k*AW +: AW]);
            e = s >= NR ? '0 : (wbe && int'(wbd) == s) ? wbr : m_reg[s];
            b = s < NR && m_cnt[s] > 0 && !(m_cnt[s] == 1 && wbe && int'(wbd) == s);
            chk($sformatf("%s.rdata%0d", tag, k), rdata[k*DW +: DW], e);
            chk($sformatf("%s.busy%0d", tag, k), {31'b0, rd_busy[k]}, {31'b0, b});
        end
        chk($sformatf("%s.stall", tag), {31'b0, stall}, {31'b0, m_stall()});
    endtask

    task automatic model_edge();
        bit st;
        st = m_stall();
        if (rst) begin
            for (int i = 0; i < NR; i++) begin m_reg[i] = i; m_cnt[i] = 0; end
        end else begin
            if (wbe && wbd < NR) m_reg[wbd] = wbr;
            for (int r = 0; r < NR; r++) begin
                bit inc, dec;
                inc = ie && idst == r && !st;
                dec = wbe && wbd == r;
                if (flush) m_cnt[r] = 0;
                else if (inc && !dec && m_cnt[r] < CMAX) m_cnt[r]++;
                else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
            end
        end
    endtask

    task automatic step(string tag);
        #1 check_outputs(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(bit r, bit we, int wd, logic [DW-1:0] wr, bit i, int id, bit fl,
                         int s0, int s1, int s2);
        rst = r; wbe = we; wbd = AW'(wd); wbr = wr; ie = i; idst = AW'(id); flush = fl;
        src = {AW'(s2), AW'(s1), AW'(s0)};
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 14);
        #1;
        chk("reset_rdata", rdata[DW-1:0], 32'd0);
        chk("reset_rdata1", rdata[2*DW-1:DW], 32'd5);
        chk("reset_rdata2", rdata[3*DW-1:2*DW], 32'd14);
        chk("reset_busy", {29'b0, rd_busy}, 32'd0);
        step("rst_read");
        drive(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 0, 1);
        #1 chk("bypass", rdata[DW-1:0], 32'hDEADBEEF);
        step("wb3");
        drive(0, 1, 15, 32'h12345678, 0, 0, 0, 15, 3, 14);
        #1 chk("pc_read", rdata[DW-1:0], 32'd0);
        step("wb15");
        drive(0, 0, 0, 0, 0, 0, 0, 3, 15, 14);
        #1 chk("r3_after", rdata[DW-1:0], 32'hDEADBEEF);
        step("after_wb15");
        for (int n = 0; n < 3; n++) begin
            drive(0, 0, 0, 0, 1, 2, 0, 2, 0, 1);
            step("issue_r2");
        end
        drive(0, 0, 0, 0, 1, 2, 0, 2, 0, 1);
        #1 chk("busy_r2", {31'b0, rd_busy[0]}, 32'd1);
        chk("stall_r2", {31'b0, stall}, 32'd1);
        step("issue_r2_stall");
        for (int n = 0; n < 3; n++) begin
            drive(0, 1, 2, 32'h100 + n, 0, 0, 0, 2, 0, 1);
            #1 chk($sformatf("busy_wb%0d", n), {31'b0, rd_busy[0]}, n == 2 ? 32'd0 : 32'd1);
            step("wb_r2");
        end
        drive(0, 0, 0, 0, 1, 4, 0, 4, 0, 0);
        step("issue_r4");
        drive(0, 1, 4, 32'h44, 1, 4, 0, 4, 0, 0);
        step("issue_wb_r4");
        drive(0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
        #1 chk("busy_r4", {31'b0, rd_busy[0]}, 32'd1);
        step("after_r4");
        drive(0, 0, 0, 0, 1, 1, 0, 1, 7, 4);
        step("issue_r1a");
        step("issue_r1b");
        drive(0, 0, 0, 0, 1, 7, 0, 1, 7, 4);
        step("issue_r7");
        drive(0, 1, 1, 32'hCAFE0001, 0, 0, 1, 1, 7, 4);
        step("flush");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 4);
        #1 chk("flush_busy", {29'b0, rd_busy}, 32'd0);
        chk("flush_data", rdata[DW-1:0], 32'hCAFE0001);
        step("after_flush");
        drive(0, 0, 0, 0, 1, 9, 0, 9, 0, 0);
        step("issue_r9");
        drive(1, 1, 9, 32'hFF, 1, 9, 0, 9, 0, 0);
        step("rst_mid");
        drive(0, 0, 0, 0, 0, 0, 0, 9, 2, 4);
        #1 chk("rst_r9", rdata[DW-1:0], 32'd9);
        chk("rst_busy", {29'b0, rd_busy}, 32'd0);
        step("after_rst");
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3),
                  $urandom, $urandom_range(0, 1) == 0,
                  $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3),
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 3));
            step("rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 4, meaning register index width.
REQ-003 SHALL provide parameter NUM_REGS, default 15, meaning stored registers R0..R(NUM_REGS-1); PC not stored.
REQ-004 SHALL provide parameter NUM_RD, default 3, meaning number of independent read ports.
REQ-005 SHALL provide parameter CNT_W, default 2, meaning width of per-register pending-write counter.
REQ-006 SHALL have ports, in order:
clk  in  1  sole clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
src  in  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  port k source has outstanding write
write_back_en  in  1  write-back strobe
WB_dest  in  ADDR_W  write-back register index
WB_result  in  DATA_W  write-back data
issue_en  in  1  instruction with destination issued this cycle
issue_dest  in  ADDR_W  destination of issued instruction
flush  in  1  clear all pending counters
issue_stall  out  1  issue would overflow counter of issue_dest

Function
REQ-007 SHALL write WB_result into register WB_dest on rising clk when write_back_en=1 and WB_dest<NUM_REGS; writes to indices >=NUM_REGS SHALL be ignored.
REQ-008 SHALL read combinationally: rdata port k = register[src_k], or 0 when src_k>=NUM_REGS.
REQ-009 SHALL bypass: if write_back_en=1 and WB_dest==src_k (<NUM_REGS), rdata port k SHALL equal WB_result in the same cycle.
REQ-010 SHALL keep a CNT_W-bit pending counter per register.
REQ-011 SHALL update counter c of register r each edge: issue-only (issue_en, issue_dest==r, not stalled) -> c+1; wb-only (write_back_en, WB_dest==r) -> c-1; both -> unchanged; neither -> unchanged.
REQ-012 SHALL floor decrement at 0 (wb to register with c=0 leaves 0).
REQ-013 SHALL assert issue_stall combinationally when issue_en=1, issue_dest<NUM_REGS, counter==2^CNT_W-1 and no same-cycle wb to that register; a stalled issue SHALL NOT change the counter.
REQ-014 SHALL ignore issue_en for issue_dest>=NUM_REGS (no counter change, no stall).
REQ-015 SHALL drive rd_busy[k]=1 when src_k<NUM_REGS and counter[src_k]>0, except 0 when counter==1 and same-cycle wb targets src_k (bypass covers it).
REQ-016 SHALL, on flush=1, zero all counters at the edge, overriding same-cycle issue/wb counter effects; register data writes SHALL still occur.

Reset
REQ-017 SHALL, on rising clk with rst=1, load register i with value i (zero-extended to DATA_W) for all i<NUM_REGS and zero all counters.
REQ-018 SHALL give rst priority over write_back_en, issue_en and flush; a write coinciding with rst is lost.
REQ-019 SHALL, after reset, present rd_busy=0 and issue_stall=0 until new issue.

Structure
REQ-020 SHALL place default parameter values and the PC index constant (15) in the shared core package.
REQ-021 SHALL implement one sub-module, reg_pending_cnt, holding a single saturating/flooring up-down counter, instantiated NUM_REGS times.

Verification
REQ-022 Reset then read src={0,5,14} -> rdata={0,5,14}, rd_busy=0.
REQ-023 write_back_en=1, WB_dest=3, WB_result=0xDEADBEEF, src0=3 same cycle -> rdata0=0xDEADBEEF that cycle and after; WB_dest=15 -> no register changes, src=15 reads 0.
REQ-024 Issue R2 three times -> counter 3, rd_busy=1 on port reading R2; fourth issue -> issue_stall=1, counter stays 3; three wbs to R2 -> busy clears in the cycle of the third wb.
REQ-025 Same cycle issue_dest=4 and WB_dest=4 with counter 1 -> counter stays 1, rd_busy stays 1.
REQ-026 Counters R1=2, R7=1, assert flush with wb to R1 -> all counters 0, R1 data updated.
REQ-027 Assert rst mid-sequence with write_back_en=1 to R9=0xFF -> R9 reads 9, all rd_busy=0.
